// File: rtl/uart_tx_sched_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encoding, source IDs,
// start-timeout length and the round-robin pick helper.
package uart_tx_sched_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LAUNCH     = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int unsigned START_TIMEOUT = 16;
    localparam int          TMO_W         = 4;

    // With both sources ready the preferred one wins, otherwise whichever is ready.
    function automatic logic rr_pick(input logic a_rdy, input logic b_rdy, input logic pref);
        return (a_rdy && b_rdy) ? pref : (b_rdy ? SRC_B : SRC_A);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO for one scheduler source; writes into a full FIFO are dropped and
// latch a sticky overflow flag.
module uart_byte_fifo
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       wr,
    output logic       full,
    input  logic       rd,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                push;
    logic                pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign push    = wr && !full;
    assign pop     = rd && !empty;
    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (wr && full)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter between the encoder
// packer (A) and the debug pattern source (B).
//
// state         | meaning
// ST_IDLE       | waiting for tx_idle and a queued byte; grants and pops
// ST_LAUNCH     | wrsig pulse, dataout already holds the byte
// ST_WAIT_START | waiting for the transmitter to go busy (16-cycle timeout)
// ST_WAIT_DONE  | waiting for the transmitter to return idle
// ST_GAP        | inter-byte gap down-counter
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int GAP_CYCLES = 254,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a_data,
    input  logic       a_wr,
    output logic       a_full,
    input  logic [7:0] b_data,
    input  logic       b_wr,
    output logic       b_full,
    input  logic       tx_idle,
    output logic [7:0] dataout,
    output logic       wrsig,
    output logic       busy,
    output logic [1:0] ovf
);

    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_ONE   = CNT_W'(1);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(START_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
    localparam logic [2:0]       POST_XFER = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    logic [2:0]       state;
    logic             rr_pref;
    logic [CNT_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic             a_empty;
    logic             b_empty;
    logic             a_ovf;
    logic             b_ovf;
    logic             grant_go;
    logic             grant_src;
    logic             a_rd;
    logic             b_rd;

    uart_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (a_data),
        .wr      (a_wr),
        .full    (a_full),
        .rd      (a_rd),
        .rd_data (a_q),
        .empty   (a_empty),
        .ovf     (a_ovf)
    );

    uart_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (b_data),
        .wr      (b_wr),
        .full    (b_full),
        .rd      (b_rd),
        .rd_data (b_q),
        .empty   (b_empty),
        .ovf     (b_ovf)
    );

    assign grant_go  = (state == ST_IDLE) && tx_idle && (!a_empty || !b_empty);
    assign grant_src = rr_pick(!a_empty, !b_empty, rr_pref);
    assign a_rd      = grant_go && (grant_src == SRC_A);
    assign b_rd      = grant_go && (grant_src == SRC_B);
    assign wrsig     = (state == ST_LAUNCH);
    assign busy      = (state != ST_IDLE) || !a_empty || !b_empty;
    assign ovf       = {b_ovf, a_ovf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rr_pref <= SRC_A;
            gap_cnt <= '0;
            tmo_cnt <= '0;
            dataout <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_go) begin
                        dataout <= (grant_src == SRC_A) ? a_q : b_q;
                        rr_pref <= ~grant_src;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    tmo_cnt <= TMO_LOAD;
                    state   <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    // A transmitter that never drops idle is assumed to have taken the byte.
                    if (!tx_idle) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo_cnt == '0) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= POST_XFER;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_ONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_idle) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= POST_XFER;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - GAP_ONE;
                    if (gap_cnt <= GAP_ONE)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus random traffic scored
// against a queue-based model of the two sources and the round-robin rule.
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int GAP   = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       a_wr = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_wr = 1'b0;
    logic       tx_idle = 1'b1;
    logic       a_full;
    logic       b_full;
    logic [7:0] dataout;
    logic       wrsig;
    logic       busy;
    logic [1:0] ovf;

    always #5 clk = ~clk;

    uart_tx_sched #(.DEPTH_LOG2(3), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_data  (a_data),
        .a_wr    (a_wr),
        .a_full  (a_full),
        .b_data  (b_data),
        .b_wr    (b_wr),
        .b_full  (b_full),
        .tx_idle (tx_idle),
        .dataout (dataout),
        .wrsig   (wrsig),
        .busy    (busy),
        .ovf     (ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-source queues, last granted source, sticky overflow.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       last_was_a;
    logic [1:0] exp_ovf;
    int         n_acc;
    logic       prev_wrsig;
    logic [7:0] launched[$];
    int         launch_cyc[$];
    int         cyc = 0;

    // Transmitter model: 0 responsive, 1 never busy, 2 held busy.
    int   tx_mode = 0;
    int   tx_dly = 0;
    int   tx_len = 0;
    int   dly_lo = 1, dly_hi = 4, len_lo = 5, len_hi = 20;
    logic tx_rose = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int sa;
        int sb;
        logic take_b;
        logic [7:0] exp_byte;
        @(posedge clk);
        #1;
        cyc++;
        sa = qa.size();
        sb = qb.size();
        if (wrsig === 1'b1) begin
            chk("wrsig_back_to_back", 32'(prev_wrsig), 32'(1'b0));
            if (sa + sb == 0) begin
                chk("spurious_wrsig", 32'(wrsig), 32'(1'b0));
            end else begin
                take_b = (sa > 0 && sb > 0) ? last_was_a : (sb > 0);
                exp_byte = take_b ? qb.pop_front() : qa.pop_front();
                last_was_a = !take_b;
                chk("launch_byte", 32'(dataout), 32'(exp_byte));
            end
            launched.push_back(dataout);
            launch_cyc.push_back(cyc);
        end
        prev_wrsig = wrsig;
        if (a_wr) begin
            if (sa < DEPTH) begin qa.push_back(a_data); n_acc++; end
            else exp_ovf[0] = 1'b1;
        end
        if (b_wr) begin
            if (sb < DEPTH) begin qb.push_back(b_data); n_acc++; end
            else exp_ovf[1] = 1'b1;
        end
        chk("ovf", 32'(ovf), 32'(exp_ovf));
        chk("a_full", 32'(a_full), 32'(qa.size() == DEPTH));
        chk("b_full", 32'(b_full), 32'(qb.size() == DEPTH));
        a_wr = 1'b0;
        b_wr = 1'b0;
        if (tx_mode == 1) begin
            tx_idle = 1'b1;
        end else if (tx_mode == 2) begin
            tx_idle = 1'b0;
        end else if (wrsig === 1'b1) begin
            tx_dly = int'($urandom_range(dly_hi, dly_lo));
        end else if (tx_dly > 0) begin
            tx_dly--;
            if (tx_dly == 0) begin
                tx_idle = 1'b0;
                tx_len = int'($urandom_range(len_hi, len_lo));
            end
        end else if (tx_len > 0) begin
            tx_len--;
            if (tx_len == 0) begin
                tx_idle = 1'b1;
                tx_rose = 1'b1;
            end
        end
    endtask

    task automatic clear_model();
        qa.delete();
        qb.delete();
        launched.delete();
        launch_cyc.delete();
        last_was_a = 1'b0;
        exp_ovf = 2'b00;
        n_acc = 0;
        prev_wrsig = 1'b0;
    endtask

    task automatic do_reset();
        a_wr = 1'b0;
        b_wr = 1'b0;
        rst_n = 1'b0;
        clear_model();
        tx_dly = 0;
        tx_len = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_quiet(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!(busy === 1'b0 && qa.size() == 0 && qb.size() == 0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk({tag, "_drain_in_time"}, 32'(n < max_cyc), 32'(1'b1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vals[9];
        logic [7:0] rr_exp[5];
        int n;
        int pa;
        int pb;
        rr_exp = '{8'h01, 8'hA1, 8'h02, 8'hA2, 8'h03};

        // Reset state
        do_reset();
        chk("rst_dataout", 32'(dataout), 32'(8'h00));
        chk("rst_wrsig", 32'(wrsig), 32'(1'b0));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_ovf", 32'(ovf), 32'(2'b00));
        chk("rst_a_full", 32'(a_full), 32'(1'b0));
        chk("rst_b_full", 32'(b_full), 32'(1'b0));

        // Single byte: latency, one pulse, gap after the transmitter returns idle
        tx_mode = 0; tx_idle = 1'b1;
        dly_lo = 3; dly_hi = 3; len_lo = 100; len_hi = 100;
        a_data = 8'h5A; a_wr = 1'b1;
        tick();
        chk("lat_no_early_wrsig", 32'(wrsig), 32'(1'b0));
        tick();
        chk("lat_wrsig", 32'(wrsig), 32'(1'b1));
        chk("lat_dataout", 32'(dataout), 32'(8'h5A));
        tx_rose = 1'b0;
        n = 0;
        while (!tx_rose && n < 300) begin tick(); n++; end
        chk("single_tx_rose", 32'(tx_rose), 32'(1'b1));
        n = 0;
        while (busy !== 1'b0 && n < 40) begin tick(); n++; end
        chk("single_gap_len", 32'(n), 32'(GAP + 1));
        repeat (10) tick();
        chk("single_busy_after", 32'(busy), 32'(1'b0));
        chk("single_pulse_count", 32'(launched.size()), 32'(1));
        chk("single_dataout_hold", 32'(dataout), 32'(8'h5A));

        // Round-robin ordering
        do_reset();
        tx_mode = 2; tx_idle = 1'b0;
        dly_lo = 1; dly_hi = 3; len_lo = 5; len_hi = 12;
        a_data = 8'h01; a_wr = 1'b1; b_data = 8'hA1; b_wr = 1'b1; tick();
        a_data = 8'h02; a_wr = 1'b1; b_data = 8'hA2; b_wr = 1'b1; tick();
        a_data = 8'h03; a_wr = 1'b1; tick();
        tx_mode = 0; tx_idle = 1'b1;
        wait_quiet(600, "rr");
        chk("rr_count", 32'(launched.size()), 32'(5));
        for (int i = 0; i < 5; i++)
            chk("rr_order", 32'(launched[i]), 32'(rr_exp[i]));

        // Overflow on source A
        do_reset();
        tx_mode = 2; tx_idle = 1'b0;
        for (int i = 0; i < 9; i++) begin
            vals[i] = 8'($urandom);
            a_data = vals[i]; a_wr = 1'b1;
            tick();
            if (i == 6) chk("ovf_not_full_at_7", 32'(a_full), 32'(1'b0));
            if (i == 7) chk("ovf_full_at_8", 32'(a_full), 32'(1'b1));
        end
        chk("ovf_flag", 32'(ovf), 32'(2'b01));
        tx_mode = 0; tx_idle = 1'b1;
        wait_quiet(800, "ovf");
        chk("ovf_out_count", 32'(launched.size()), 32'(8));
        for (int i = 0; i < 8; i++)
            chk("ovf_out_order", 32'(launched[i]), 32'(vals[i]));
        chk("ovf_sticky", 32'(ovf), 32'(2'b01));

        // Start timeout: transmitter never leaves idle
        do_reset();
        tx_mode = 1; tx_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vals[i] = 8'($urandom);
            b_data = vals[i]; b_wr = 1'b1;
            tick();
        end
        wait_quiet(300, "tmo");
        chk("tmo_count", 32'(launched.size()), 32'(3));
        for (int i = 0; i < 3; i++)
            chk("tmo_bytes", 32'(launched[i]), 32'(vals[i]));
        for (int i = 1; i < 3; i++)
            chk("tmo_spacing", 32'(launch_cyc[i] - launch_cyc[i-1]), 32'(1 + 16 + GAP + 1));

        // Write coincident with pop on a full FIFO
        do_reset();
        tx_mode = 2; tx_idle = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vals[i] = 8'($urandom);
            a_data = vals[i]; a_wr = 1'b1;
            tick();
        end
        chk("sim_full", 32'(a_full), 32'(1'b1));
        tx_mode = 0; tx_idle = 1'b1;
        a_data = 8'hEE; a_wr = 1'b1;
        tick();
        chk("sim_wrsig", 32'(wrsig), 32'(1'b1));
        chk("sim_ovf", 32'(ovf), 32'(2'b01));
        chk("sim_count7_not_full", 32'(a_full), 32'(1'b0));
        wait_quiet(800, "sim");
        chk("sim_out_count", 32'(launched.size()), 32'(8));
        for (int i = 0; i < 8; i++)
            chk("sim_out_order", 32'(launched[i]), 32'(vals[i]));

        // Reset while waiting for the transmitter to finish
        do_reset();
        tx_mode = 0; tx_idle = 1'b1;
        dly_lo = 2; dly_hi = 2; len_lo = 60; len_hi = 60;
        for (int i = 0; i < 4; i++) begin
            b_data = 8'($urandom); b_wr = 1'b1;
            tick();
        end
        n = 0;
        while (tx_idle !== 1'b0 && n < 50) begin tick(); n++; end
        repeat (3) tick();
        chk("mid_busy_before", 32'(busy), 32'(1'b1));
        chk("mid_queued", 32'(qb.size()), 32'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wrsig", 32'(wrsig), 32'(1'b0));
        chk("mid_rst_dataout", 32'(dataout), 32'(8'h00));
        chk("mid_rst_busy", 32'(busy), 32'(1'b0));
        chk("mid_rst_b_full", 32'(b_full), 32'(1'b0));
        clear_model();
        repeat (3) tick();
        rst_n = 1'b1;
        tx_rose = 1'b0;
        n = 0;
        while (!tx_rose && n < 200) begin tick(); n++; end
        repeat (30) tick();
        chk("mid_no_launch", 32'(launched.size()), 32'(0));
        chk("mid_idle_after", 32'(busy), 32'(1'b0));
        b_data = 8'h3C; b_wr = 1'b1;
        tick();
        wait_quiet(300, "mid");
        chk("mid_new_launch", 32'(launched.size()), 32'(1));
        chk("mid_new_byte", 32'(launched[0]), 32'(8'h3C));

        // Random traffic, light then heavy (overflowing) load
        do_reset();
        tx_mode = 0; tx_idle = 1'b1;
        dly_lo = 1; dly_hi = 4; len_lo = 3; len_hi = 25;
        for (int i = 0; i < 3000; i++) begin
            pa = (i < 1500) ? 3 : 30;
            pb = (i < 1500) ? 2 : 25;
            if ($urandom_range(99, 0) < pa) begin a_data = 8'($urandom); a_wr = 1'b1; end
            if ($urandom_range(99, 0) < pb) begin b_data = 8'($urandom); b_wr = 1'b1; end
            tick();
        end
        wait_quiet(3000, "rand");
        chk("rand_launch_total", 32'(launched.size()), 32'(n_acc));
        chk("rand_busy_end", 32'(busy), 32'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
